// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calculator datapath blocks.
package calc_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_DIGITS  = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3_digit
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_DIGIT_W'(5)) ? i_digit + BCD_DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/accum_bcd_converter.sv
// Converts a signed accumulator result to sign-magnitude packed BCD,
// one double-dabble step per cycle.
module accum_bcd_converter
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          sign,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [3:0]                    num_digits
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mag;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_sign;
  logic               r_in_ready;
  logic               r_out_valid;

  state_t             nxt_state;
  logic [CNT_W-1:0]   nxt_cnt;
  logic [WIDTH-1:0]   nxt_mag;
  logic [BCD_W-1:0]   nxt_bcd;
  logic               nxt_sign;
  logic               nxt_in_ready;
  logic               nxt_out_valid;

  logic [BCD_W-1:0]   w_adj;
  logic [3:0]         w_num_digits;

  // Per-digit +3 correction applied to the current BCD register
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_digit (r_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mag       <= '0;
      r_bcd       <= '0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= nxt_state;
      r_cnt       <= nxt_cnt;
      r_mag       <= nxt_mag;
      r_bcd       <= nxt_bcd;
      r_sign      <= nxt_sign;
      r_in_ready  <= nxt_in_ready;
      r_out_valid <= nxt_out_valid;
    end
  end

  always_comb begin
    nxt_state     = r_state;
    nxt_cnt       = r_cnt;
    nxt_mag       = r_mag;
    nxt_bcd       = r_bcd;
    nxt_sign      = r_sign;
    nxt_in_ready  = r_in_ready;
    nxt_out_valid = r_out_valid;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          // Two's-complement negate; the most negative value lands on 2^(WIDTH-1)
          nxt_sign     = value[WIDTH-1];
          nxt_mag      = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
          nxt_bcd      = '0;
          nxt_cnt      = CNT_W'(WIDTH);
          nxt_state    = S_SHIFT;
          nxt_in_ready = 1'b0;
        end
      end
      S_SHIFT: begin
        nxt_bcd = {w_adj[BCD_W-2:0], r_mag[WIDTH-1]};
        nxt_mag = {r_mag[WIDTH-2:0], 1'b0};
        nxt_cnt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          nxt_state     = S_DONE;
          nxt_out_valid = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          nxt_state     = S_IDLE;
          nxt_out_valid = 1'b0;
          nxt_in_ready  = 1'b1;
        end
      end
      default: begin
        nxt_state     = S_IDLE;
        nxt_out_valid = 1'b0;
        nxt_in_ready  = 1'b1;
      end
    endcase
  end

  // Highest nonzero digit position plus one, never below 1
  always_comb begin
    w_num_digits = 4'd1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W] != '0) w_num_digits = 4'(d + 1);
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign sign       = r_sign;
  assign bcd        = r_bcd;
  assign num_digits = w_num_digits;

endmodule

// File: tb/tb_accum_bcd_converter.sv
// Randomized self-checking bench for accum_bcd_converter against a
// decimal-arithmetic reference model.
module tb_accum_bcd_converter;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DIGITS = 10;
  localparam int          BOUND  = 200;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      value;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sign;
  logic [4*DIGITS-1:0]   bcd;
  logic [3:0]            num_digits;

  int n_vec;
  int n_err;

  accum_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .value      (value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign       (sign),
    .bcd        (bcd),
    .num_digits (num_digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal digits of |v| built with plain division
  function automatic logic [4*DIGITS-1:0] ref_bcd(input logic [WIDTH-1:0] v);
    logic [4*DIGITS-1:0] r;
    longint s;
    s = longint'($signed(v));
    if (s < 0) s = -s;
    r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_nd(input logic [4*DIGITS-1:0] b);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 0; i < int'(DIGITS); i++)
      if (b[4*i +: 4] != 4'd0) n = 4'(i + 1);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, measure latency, check result, hold, release
  task automatic convert(input logic [WIDTH-1:0] v, input int hold, input bit scramble);
    logic [4*DIGITS-1:0] exp_bcd;
    int k;
    bit ready_seen;
    exp_bcd = ref_bcd(v);
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    value    = v;
    tick();
    in_valid = 1'b0;
    chk("in_ready_busy", 64'(in_ready), 64'(0));
    k = 0;
    ready_seen = 1'b0;
    while (!out_valid && k < BOUND) begin
      if (scramble) begin
        in_valid = 1'($urandom);
        value    = $urandom;
      end
      tick();
      k++;
      if (in_ready) ready_seen = 1'b1;
    end
    in_valid = 1'b0;
    chk("latency", 64'(k), 64'(WIDTH));
    chk("bcd", 64'(bcd), 64'(exp_bcd));
    chk("sign", 64'(sign), 64'(v[WIDTH-1]));
    chk("num_digits", 64'(num_digits), 64'(ref_nd(exp_bcd)));
    if (scramble) chk("in_ready_shift", 64'(ready_seen), 64'(0));
    for (int i = 0; i < hold; i++) tick();
    if (hold > 0) begin
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_bcd", 64'(bcd), 64'(exp_bcd));
      chk("hold_sign", 64'(sign), 64'(v[WIDTH-1]));
      chk("hold_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", 64'(out_valid), 64'(0));
    chk("release_ready", 64'(in_ready), 64'(1));
    chk("idle_bcd_kept", 64'(bcd), 64'(exp_bcd));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_bcd"}, 64'(bcd), 64'(0));
    chk({tag, "_sign"}, 64'(sign), 64'(0));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    value     = '0;
    #12;
    check_reset_state("por");
    reset = 1'b0;
    tick();

    convert(32'd12345, 0, 1'b0);
    convert(32'h7FFFFFFF, 1, 1'b0);
    convert(32'h80000000, 0, 1'b0);
    convert(32'hFFFFFFFF, 2, 1'b0);

    // Reset while idle with a negative result held
    #3 reset = 1'b1;
    #1 check_reset_state("rst_idle");
    tick();
    reset = 1'b0;
    tick();

    convert(32'd0, 0, 1'b1);
    convert(32'hFFFFF000, 20, 1'b0);
    convert(-32'sd987654321, 0, 1'b1);

    // Reset mid-conversion, away from any clock edge
    in_valid = 1'b1;
    value    = 32'd999;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    #3 reset = 1'b1;
    #1 check_reset_state("rst_mid");
    tick();
    reset = 1'b0;
    tick();
    convert(32'd999, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [WIDTH-1:0] rv;
      case ($urandom_range(0, 3))
        0:       rv = $urandom_range(0, 99);
        1:       rv = 32'hFFFFFFFF - $urandom_range(0, 99);
        default: rv = $urandom;
      endcase
      convert(rv, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
